// File: rtl/in_order_response_router_pkg.sv
// Shared definitions for the in-order response router and its upstream arbiter.
// Holds the source-tag width derivation and the flattened-bus slice helper.
`ifndef IN_ORDER_RESPONSE_ROUTER_PKG_SV
`define IN_ORDER_RESPONSE_ROUTER_PKG_SV

// Slice i of a flattened bus built from equal-width fields of w bits.
`define FLAT_SLICE(vec, i, w) vec[(i)*(w) +: (w)]

package in_order_response_router_pkg;

    localparam int HOL_CNT_W = 32;

    // Source tag width: ceil(log2(n)), never narrower than one bit.
    function automatic int req_log2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

`endif

// File: rtl/in_order_response_router_tag_fifo.sv
// router_tag_fifo: circular tag queue with push-while-full-and-popping support,
// full/empty flags and a sticky overflow flag for pushes that had to be dropped.
module router_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == FULL_CNT);
    assign empty_o    = (count_q == '0);
    assign head_o     = mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    always_comb begin
        pop_ok     = pop_i & ~empty_o;
        push_ok    = push_i & (~full_o | pop_ok);
        rd_ptr_d   = pop_ok  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d   = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        overflow_d = overflow_q | (push_i & ~push_ok);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only read below a valid count.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/in_order_response_router.sv
// Return-path router: tags each issued request with its source and steers in-order
// responses to per-requester output registers. Option: RESPONSE_ROUTER_PERF_COUNTER_EN.
module in_order_response_router
    import in_order_response_router_pkg::*;
#(
    parameter int SINGLE_RESPONSE_WIDTH_IN_BITS = 64,
    parameter int NUM_REQUEST                   = 3,
    parameter int TAG_QUEUE_SIZE                = 4,
    parameter int NUM_REQUEST_LOG2              = req_log2(NUM_REQUEST)
) (
    input  logic                                                 clk_in,
    input  logic                                                 reset_in,
    input  logic                                                 issue_valid_in,
    input  logic [NUM_REQUEST_LOG2-1:0]                          issue_source_in,
    output logic                                                 tag_queue_full_out,
    output logic                                                 overflow_error_out,
    input  logic [SINGLE_RESPONSE_WIDTH_IN_BITS-1:0]             response_in,
    input  logic                                                 response_valid_in,
    output logic                                                 issue_ack_out,
    output logic [SINGLE_RESPONSE_WIDTH_IN_BITS*NUM_REQUEST-1:0] response_flatted_out,
    output logic [NUM_REQUEST-1:0]                               response_valid_flatted_out,
    input  logic [NUM_REQUEST-1:0]                               issue_ack_flatted_in
`ifdef RESPONSE_ROUTER_PERF_COUNTER_EN
    ,
    output logic [HOL_CNT_W-1:0]                                 hol_stall_cycles_out
`endif
);
    localparam int W = SINGLE_RESPONSE_WIDTH_IN_BITS;

    logic [NUM_REQUEST_LOG2-1:0] head;
    logic                        tag_empty;
    logic                        head_busy;
    logic                        accept;

    router_tag_fifo #(
        .DEPTH (TAG_QUEUE_SIZE),
        .WIDTH (NUM_REQUEST_LOG2)
    ) u_tag_fifo (
        .clk_i       (clk_in),
        .rst_i       (reset_in),
        .push_i      (issue_valid_in),
        .push_data_i (issue_source_in),
        .pop_i       (accept),
        .head_o      (head),
        .full_o      (tag_queue_full_out),
        .empty_o     (tag_empty),
        .overflow_o  (overflow_error_out)
    );

    // An out-of-range head tag matches no port, so it never blocks and its response is dropped.
    always_comb begin
        head_busy = 1'b0;
        for (int i = 0; i < NUM_REQUEST; i++) begin
            if (head == NUM_REQUEST_LOG2'(i)) begin
                head_busy = response_valid_flatted_out[i] & ~issue_ack_flatted_in[i];
            end
        end
    end

    assign accept        = response_valid_in & ~tag_empty & ~head_busy;
    assign issue_ack_out = accept;

    for (genvar gi = 0; gi < NUM_REQUEST; gi++) begin : g_port
        logic         valid_q, valid_d;
        logic [W-1:0] data_q, data_d;
        logic         load;
        logic         clr;

        assign load = accept & (head == NUM_REQUEST_LOG2'(gi));
        assign clr  = issue_ack_flatted_in[gi] & valid_q;

        always_comb begin
            valid_d = valid_q;
            data_d  = data_q;
            if (load) begin
                valid_d = 1'b1;
                data_d  = response_in;
            end else if (clr) begin
                valid_d = 1'b0;
                data_d  = '0;
            end
        end

        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else begin
                valid_q <= valid_d;
                data_q  <= data_d;
            end
        end

        assign response_valid_flatted_out[gi]           = valid_q;
        assign `FLAT_SLICE(response_flatted_out, gi, W) = data_q;
    end

`ifdef RESPONSE_ROUTER_PERF_COUNTER_EN
    logic [HOL_CNT_W-1:0] hol_cnt_q, hol_cnt_d;

    always_comb begin
        hol_cnt_d = hol_cnt_q;
        if (response_valid_in & ~tag_empty & ~accept & (hol_cnt_q != '1)) begin
            hol_cnt_d = hol_cnt_q + HOL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            hol_cnt_q <= '0;
        end else begin
            hol_cnt_q <= hol_cnt_d;
        end
    end

    assign hol_stall_cycles_out = hol_cnt_q;
`endif

endmodule

// File: tb/tb_in_order_response_router.sv
// Directed bench for in_order_response_router: ordering, full/overflow, head-of-line,
// empty-queue, illegal tag and mid-flight reset; counter check with RESPONSE_ROUTER_PERF_COUNTER_EN.
module tb_in_order_response_router;
    localparam int W  = 64;
    localparam int N  = 3;
    localparam int LW = 2;

    logic           clk_in = 1'b0;
    logic           reset_in;
    logic           issue_valid_in;
    logic [LW-1:0]  issue_source_in;
    logic           tag_queue_full_out;
    logic           overflow_error_out;
    logic [W-1:0]   response_in;
    logic           response_valid_in;
    logic           issue_ack_out;
    logic [W*N-1:0] response_flatted_out;
    logic [N-1:0]   response_valid_flatted_out;
    logic [N-1:0]   issue_ack_flatted_in;
`ifdef RESPONSE_ROUTER_PERF_COUNTER_EN
    logic [31:0]    hol_stall_cycles_out;
`endif

    int vec_cnt = 0;
    int err_cnt = 0;

    in_order_response_router #(
        .SINGLE_RESPONSE_WIDTH_IN_BITS (W),
        .NUM_REQUEST                   (N),
        .TAG_QUEUE_SIZE                (4)
    ) dut (
        .clk_in                     (clk_in),
        .reset_in                   (reset_in),
        .issue_valid_in             (issue_valid_in),
        .issue_source_in            (issue_source_in),
        .tag_queue_full_out         (tag_queue_full_out),
        .overflow_error_out         (overflow_error_out),
        .response_in                (response_in),
        .response_valid_in          (response_valid_in),
        .issue_ack_out              (issue_ack_out),
        .response_flatted_out       (response_flatted_out),
        .response_valid_flatted_out (response_valid_flatted_out),
        .issue_ack_flatted_in       (issue_ack_flatted_in)
`ifdef RESPONSE_ROUTER_PERF_COUNTER_EN
        ,
        .hol_stall_cycles_out       (hol_stall_cycles_out)
`endif
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [W*N-1:0] obs, input logic [W*N-1:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_ports(input string tag, input logic [N-1:0] v, input logic [W*N-1:0] d);
        chk({tag, "_valid"}, (W*N)'(response_valid_flatted_out), (W*N)'(v));
        chk({tag, "_data"}, response_flatted_out, d);
    endtask

    task automatic issue(input logic [LW-1:0] src);
        issue_valid_in  = 1'b1;
        issue_source_in = src;
        tick();
        issue_valid_in  = 1'b0;
    endtask

    initial begin
        reset_in             = 1'b1;
        issue_valid_in       = 1'b0;
        issue_source_in      = '0;
        response_in          = '0;
        response_valid_in    = 1'b0;
        issue_ack_flatted_in = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_ports("rst", 3'b000, '0);
        chk("rst_full", (W*N)'(tag_queue_full_out), 0);
        chk("rst_ovf", (W*N)'(overflow_error_out), 0);
        chk("rst_ack", (W*N)'(issue_ack_out), 0);
        reset_in = 1'b0;
        tick();

        // Ordering: sources 2,0,1 then responses A,B,C, each consumed immediately.
        issue(2); issue(0); issue(1);
        response_valid_in = 1'b1;
        response_in = 64'hA;
        #1 chk("ord_ack_a", (W*N)'(issue_ack_out), 1);
        tick();
        chk_ports("ord_a", 3'b100, {64'hA, 64'h0, 64'h0});
        response_in = 64'hB;
        issue_ack_flatted_in = 3'b100;
        #1 chk("ord_ack_b", (W*N)'(issue_ack_out), 1);
        tick();
        chk_ports("ord_b", 3'b001, {64'h0, 64'h0, 64'hB});
        response_in = 64'hC;
        issue_ack_flatted_in = 3'b001;
        #1 chk("ord_ack_c", (W*N)'(issue_ack_out), 1);
        tick();
        chk_ports("ord_c", 3'b010, {64'h0, 64'hC, 64'h0});
        response_valid_in = 1'b0;
        issue_ack_flatted_in = 3'b010;
        tick();
        issue_ack_flatted_in = '0;
        chk_ports("ord_end", 3'b000, '0);

        // Full: four tags fill the queue; a fifth with a pop is fine, a sixth overflows.
        issue(0); issue(1); issue(2); issue(0);
        chk("full_set", (W*N)'(tag_queue_full_out), 1);
        issue_valid_in = 1'b1;
        issue_source_in = 2'd1;
        response_valid_in = 1'b1;
        response_in = 64'h11;
        #1 chk("full_pop_ack", (W*N)'(issue_ack_out), 1);
        tick();
        response_valid_in = 1'b0;
        chk("full_still", (W*N)'(tag_queue_full_out), 1);
        chk("full_no_ovf", (W*N)'(overflow_error_out), 0);
        chk_ports("full_p0", 3'b001, {64'h0, 64'h0, 64'h11});
        tick();
        issue_valid_in = 1'b0;
        chk("ovf_set", (W*N)'(overflow_error_out), 1);
        // Queue now holds 1,2,0,1.
        response_valid_in = 1'b1;
        response_in = 64'h21; issue_ack_flatted_in = 3'b001; tick();
        chk_ports("drain1", 3'b010, {64'h0, 64'h21, 64'h0});
        response_in = 64'h22; issue_ack_flatted_in = 3'b010; tick();
        chk_ports("drain2", 3'b100, {64'h22, 64'h0, 64'h0});
        response_in = 64'h23; issue_ack_flatted_in = 3'b100; tick();
        chk_ports("drain3", 3'b001, {64'h0, 64'h0, 64'h23});
        response_in = 64'h24; issue_ack_flatted_in = 3'b001; tick();
        chk_ports("drain4", 3'b010, {64'h0, 64'h24, 64'h0});
        response_valid_in = 1'b0; issue_ack_flatted_in = 3'b010; tick();
        issue_ack_flatted_in = '0;
        chk("ovf_sticky", (W*N)'(overflow_error_out), 1);
        chk("full_clear", (W*N)'(tag_queue_full_out), 0);

        // Out-of-range source: response popped but routed nowhere.
        issue(3); issue(0);
        response_valid_in = 1'b1;
        response_in = 64'h51;
        #1 chk("ill_ack", (W*N)'(issue_ack_out), 1);
        tick();
        chk_ports("ill_drop", 3'b000, '0);
        response_in = 64'h52; tick();
        chk_ports("ill_next", 3'b001, {64'h0, 64'h0, 64'h52});
        response_valid_in = 1'b0; issue_ack_flatted_in = 3'b001; tick();
        issue_ack_flatted_in = '0;

        // Reset mid-flight: three tags outstanding, port0 holding data.
        issue(0); issue(1); issue(2);
        issue_valid_in = 1'b1;
        issue_source_in = 2'd1;
        response_valid_in = 1'b1;
        response_in = 64'h31;
        tick();
        issue_valid_in = 1'b0;
        response_valid_in = 1'b0;
        chk_ports("pre_rst", 3'b001, {64'h0, 64'h0, 64'h31});
        #2 reset_in = 1'b1;
        #1;
        chk_ports("mid_rst", 3'b000, '0);
        chk("mid_rst_full", (W*N)'(tag_queue_full_out), 0);
        chk("mid_rst_ovf", (W*N)'(overflow_error_out), 0);
        tick();
        reset_in = 1'b0;

        // Empty queue: no bypass even with a same-cycle issue.
        response_valid_in = 1'b1;
        response_in = 64'h61;
        issue_valid_in = 1'b1;
        issue_source_in = 2'd2;
        #1 chk("empty_ack", (W*N)'(issue_ack_out), 0);
        tick();
        issue_valid_in = 1'b0;
        #1 chk("empty_retry_ack", (W*N)'(issue_ack_out), 1);
        tick();
        response_valid_in = 1'b0;
        chk_ports("empty_p2", 3'b100, {64'h61, 64'h0, 64'h0});
        issue_ack_flatted_in = 3'b100; tick();
        issue_ack_flatted_in = '0;

        // Head-of-line: tags 1,1,2; port1 held for five cycles.
        issue(1); issue(1); issue(2);
        response_valid_in = 1'b1;
        response_in = 64'h41;
        tick();
        chk_ports("hol_first", 3'b010, {64'h0, 64'h41, 64'h0});
        response_in = 64'h42;
        for (int k = 0; k < 5; k++) begin
            #1 chk("hol_stall_ack", (W*N)'(issue_ack_out), 0);
            tick();
        end
        chk_ports("hol_held", 3'b010, {64'h0, 64'h41, 64'h0});
        issue_ack_flatted_in = 3'b010;
        #1 chk("hol_release_ack", (W*N)'(issue_ack_out), 1);
        tick();
        chk_ports("hol_reload", 3'b010, {64'h0, 64'h42, 64'h0});
`ifdef RESPONSE_ROUTER_PERF_COUNTER_EN
        chk("hol_cnt", (W*N)'(hol_stall_cycles_out), 5);
`endif
        response_in = 64'h43;
        tick();
        chk_ports("hol_tail", 3'b100, {64'h43, 64'h0, 64'h0});
        response_valid_in = 1'b0;
        issue_ack_flatted_in = 3'b100;
        tick();
        issue_ack_flatted_in = '0;
        chk_ports("hol_end", 3'b000, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
